// File: rtl/game_flow_controller.sv
// Turn sequencer for a multi-player board game: welcome, board init, per-player move/pass, game over.
// Optional per-turn forfeit timer is built when GFC_MOVE_TIMEOUT_EN is defined.
module game_flow_controller #(
    parameter int NUM_PLAYERS    = 2,
    parameter int FIRST_PLAYER   = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int PW = ($clog2(NUM_PLAYERS) < 1) ? 1 : $clog2(NUM_PLAYERS),
    localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          go,
    input  logic          init_end,
    input  logic          ack,
    input  logic          no_move,
    input  logic          game_end,
    output logic          init_start,
    output logic          new_move,
    output logic [PW-1:0] player,
    output logic [PW:0]   pass_cnt,
    output logic          timeout,
    output logic          game_over
);

    typedef enum logic [2:0] {
        WELC = 3'd0,
        INIT = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        PASS = 3'd4,
        OVER = 3'd5
    } state_t;

    localparam logic [PW-1:0] FIRST_P     = PW'(FIRST_PLAYER);
    localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
    localparam logic [PW:0]   PASS_LIMIT  = (PW+1)'(NUM_PLAYERS);

    // Parameter sanity, caught at elaboration rather than as odd runtime behaviour.
    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 16) begin : g_bad_num_players
        $error("game_flow_controller: NUM_PLAYERS must be 2..16");
    end
    if (FIRST_PLAYER < 0 || FIRST_PLAYER >= NUM_PLAYERS) begin : g_bad_first_player
        $error("game_flow_controller: FIRST_PLAYER must be 0..NUM_PLAYERS-1");
    end
    if (TIMEOUT_CYCLES < 2 || TW < 1) begin : g_bad_timeout
        $error("game_flow_controller: TIMEOUT_CYCLES must be at least 2");
    end

    state_t        state_q, state_d;
    logic [PW-1:0] player_q, player_d;
    logic [PW:0]   pass_cnt_q, pass_cnt_d;
    logic [PW-1:0] next_player;
    logic [PW:0]   pass_inc;
    logic          turn_expired;

`ifdef GFC_MOVE_TIMEOUT_EN
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;

    assign turn_expired = (timer_q == TIMER_LAST);
`else
    assign turn_expired = 1'b0;
`endif

    assign next_player = (player_q == LAST_PLAYER) ? '0 : player_q + PW'(1);
    assign pass_inc    = pass_cnt_q + (PW+1)'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WELC;
        end else begin
            state_q <= state_d;
        end
    end

    // Turn bookkeeping; these hold in every state that does not explicitly update them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            player_q   <= FIRST_P;
            pass_cnt_q <= '0;
`ifdef GFC_MOVE_TIMEOUT_EN
            timer_q    <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            player_q   <= player_d;
            pass_cnt_q <= pass_cnt_d;
`ifdef GFC_MOVE_TIMEOUT_EN
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        pass_cnt_d = pass_cnt_q;
`ifdef GFC_MOVE_TIMEOUT_EN
        timer_d    = timer_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            WELC: begin
                if (go) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                if (init_end) begin
                    state_d    = WAIT;
                    player_d   = FIRST_P;
                    pass_cnt_d = '0;
`ifdef GFC_MOVE_TIMEOUT_EN
                    timer_d    = '0;
`endif
                end
            end
            WAIT: begin
                if (game_end) begin
                    state_d = OVER;
                end else if (ack) begin
                    state_d    = HOLD;
                    pass_cnt_d = '0;
                end else if (no_move || turn_expired) begin
                    // Everyone passing in a row ends the game without a further turn.
                    pass_cnt_d = pass_inc;
                    if (pass_inc == PASS_LIMIT) begin
                        state_d = OVER;
                    end else begin
                        state_d  = PASS;
                        player_d = next_player;
`ifdef GFC_MOVE_TIMEOUT_EN
                        timeout_d = !no_move;
`endif
                    end
                end else begin
`ifdef GFC_MOVE_TIMEOUT_EN
                    timer_d = timer_q + TW'(1);
`endif
                end
            end
            HOLD: begin
                if (game_end) begin
                    state_d = OVER;
                end else if (!ack) begin
                    state_d  = WAIT;
                    player_d = next_player;
`ifdef GFC_MOVE_TIMEOUT_EN
                    timer_d  = '0;
`endif
                end
            end
            PASS: begin
                if (game_end) begin
                    state_d = OVER;
                end else begin
                    state_d = WAIT;
`ifdef GFC_MOVE_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            OVER: begin
                if (go) begin
                    state_d = INIT;
                end
            end
            default: begin
                state_d = WELC;
            end
        endcase
    end

    always_comb begin
        init_start = (state_q == INIT);
        new_move   = (state_q == WAIT);
        game_over  = (state_q == OVER);
    end

    assign player   = player_q;
    assign pass_cnt = pass_cnt_q;
`ifdef GFC_MOVE_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller: a 2-player instance and a 3-player instance starting at player 2.
module tb_game_flow_controller;

    localparam int E_WELC = 0;
    localparam int E_INIT = 1;
    localparam int E_WAIT = 2;
    localparam int E_HOLD = 3;
    localparam int E_PASS = 4;
    localparam int E_OVER = 5;

    // Input vector layout: {go, init_end, ack, no_move, game_end}
    localparam logic [4:0] I_NONE = 5'b00000;
    localparam logic [4:0] I_GO   = 5'b10000;
    localparam logic [4:0] I_IE   = 5'b01000;
    localparam logic [4:0] I_ACK  = 5'b00100;
    localparam logic [4:0] I_NM   = 5'b00010;
    localparam logic [4:0] I_GE   = 5'b00001;

    typedef struct {
        int due;
        int dut;
        int exp_state;
        int exp_player;
        int exp_pass;
        int exp_timeout;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    exp_t  exp_q[$];
    string name_q[$];

    logic       go_a, init_end_a, ack_a, no_move_a, game_end_a;
    logic       init_start_a, new_move_a, timeout_a, game_over_a;
    logic [0:0] player_a;
    logic [1:0] pass_cnt_a;

    logic       go_b, init_end_b, ack_b, no_move_b, game_end_b;
    logic       init_start_b, new_move_b, timeout_b, game_over_b;
    logic [1:0] player_b;
    logic [2:0] pass_cnt_b;

    game_flow_controller #(.NUM_PLAYERS(2), .FIRST_PLAYER(0), .TIMEOUT_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .go(go_a), .init_end(init_end_a), .ack(ack_a),
        .no_move(no_move_a), .game_end(game_end_a), .init_start(init_start_a),
        .new_move(new_move_a), .player(player_a), .pass_cnt(pass_cnt_a),
        .timeout(timeout_a), .game_over(game_over_a)
    );

    game_flow_controller #(.NUM_PLAYERS(3), .FIRST_PLAYER(2), .TIMEOUT_CYCLES(4)) dut_b (
        .clock(clock), .reset(reset), .go(go_b), .init_end(init_end_b), .ack(ack_b),
        .no_move(no_move_b), .game_end(game_end_b), .init_start(init_start_b),
        .new_move(new_move_b), .player(player_b), .pass_cnt(pass_cnt_b),
        .timeout(timeout_b), .game_over(game_over_b)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input exp_t e, input string name);
        logic [3:0] act_flags, exp_flags;
        logic [3:0] act_pl, exp_pl;
        logic [4:0] act_pc, exp_pc;
        if (e.dut == 0) begin
            act_flags = {init_start_a, new_move_a, game_over_a, timeout_a};
            act_pl    = {3'b000, player_a};
            act_pc    = {3'b000, pass_cnt_a};
        end else begin
            act_flags = {init_start_b, new_move_b, game_over_b, timeout_b};
            act_pl    = {2'b00, player_b};
            act_pc    = {2'b00, pass_cnt_b};
        end
        exp_flags = {e.exp_state == E_INIT, e.exp_state == E_WAIT,
                     e.exp_state == E_OVER, e.exp_timeout != 0};
        exp_pl = 4'(e.exp_player);
        exp_pc = 5'(e.exp_pass);
        n_vec++;
        if ({act_flags, act_pl, act_pc} !== {exp_flags, exp_pl, exp_pc}) begin
            n_fail++;
            $display("[TB] FAIL %s dut%0d: got init/move/over/tmo=%b player=%0d pass=%0d, want init/move/over/tmo=%b player=%0d pass=%0d",
                     name, e.dut, act_flags, act_pl, act_pc, exp_flags, exp_pl, exp_pc);
        end
    endtask

    // Monitor: drains every expectation whose due cycle has arrived, on clock edges and async resets.
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            #1;
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                checkOutput(exp_q.pop_front(), name_q.pop_front());
            end
        end
    end

    task automatic setInputs(input int d, input logic [4:0] v);
        if (d == 0) begin
            {go_a, init_end_a, ack_a, no_move_a, game_end_a} = v;
        end else begin
            {go_b, init_end_b, ack_b, no_move_b, game_end_b} = v;
        end
    endtask

    task automatic expectOutput(input string name, input int d, input int st, input int pl,
                                input int pc, input int to, input int due);
        exp_t e;
        e.due = due; e.dut = d; e.exp_state = st;
        e.exp_player = pl; e.exp_pass = pc; e.exp_timeout = to;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic applyStimulus(input string name, input int d, input logic [4:0] v,
                                 input int st, input int pl, input int pc, input int to);
        @(negedge clock);
        setInputs(d, v);
        expectOutput(name, d, st, pl, pc, to, cyc + 1);
    endtask

    initial begin
        reset = 1'b1;
        setInputs(0, I_NONE);
        setInputs(1, I_NONE);
        repeat (2) @(negedge clock);
        expectOutput("reset_a", 0, E_WELC, 0, 0, 0, cyc + 1);
        expectOutput("reset_b", 1, E_WELC, 2, 0, 0, cyc + 1);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus("welc_idle", 0, I_ACK, E_WELC, 0, 0, 0);

        // 3 players starting at 2: one move wraps to player 0
        applyStimulus("b_go",      1, I_GO,   E_INIT, 2, 0, 0);
        applyStimulus("b_init",    1, I_IE,   E_WAIT, 2, 0, 0);
        applyStimulus("b_ack",     1, I_ACK,  E_HOLD, 2, 0, 0);
        applyStimulus("b_wrap",    1, I_NONE, E_WAIT, 0, 0, 0);

        // 2 players: ack held 3 cycles then released
        applyStimulus("a_go",        0, I_GO,   E_INIT, 0, 0, 0);
        applyStimulus("a_init",      0, I_IE,   E_WAIT, 0, 0, 0);
        applyStimulus("a_hold1",     0, I_ACK,  E_HOLD, 0, 0, 0);
        applyStimulus("a_hold2",     0, I_ACK,  E_HOLD, 0, 0, 0);
        applyStimulus("a_hold3",     0, I_ACK,  E_HOLD, 0, 0, 0);
        applyStimulus("a_release",   0, I_NONE, E_WAIT, 1, 0, 0);
        applyStimulus("a_pass1",     0, I_NM,   E_PASS, 0, 1, 0);
        applyStimulus("a_pass_1cyc", 0, I_NM,   E_WAIT, 0, 1, 0);
        applyStimulus("a_ack_clr",   0, I_ACK,  E_HOLD, 0, 0, 0);
        applyStimulus("a_rel2",      0, I_NONE, E_WAIT, 1, 0, 0);
        applyStimulus("a_pass_a",    0, I_NM,   E_PASS, 0, 1, 0);
        applyStimulus("a_back",      0, I_NONE, E_WAIT, 0, 1, 0);
        applyStimulus("a_all_pass",  0, I_NM,   E_OVER, 0, 2, 0);
        applyStimulus("a_over_ack",  0, I_ACK,  E_OVER, 0, 2, 0);
        applyStimulus("a_rematch",   0, I_GO,   E_INIT, 0, 2, 0);
        applyStimulus("a_reinit",    0, I_IE,   E_WAIT, 0, 0, 0);
        applyStimulus("a_pass_b",    0, I_NM,   E_PASS, 1, 1, 0);
        applyStimulus("a_back2",     0, I_NONE, E_WAIT, 1, 1, 0);
        applyStimulus("a_ack_ge",    0, I_ACK | I_GE, E_OVER, 1, 1, 0);
        applyStimulus("a_rematch2",  0, I_GO,   E_INIT, 1, 1, 0);
        applyStimulus("a_reinit2",   0, I_IE,   E_WAIT, 0, 0, 0);

`ifdef GFC_MOVE_TIMEOUT_EN
        applyStimulus("tmo_w1",    0, I_NONE, E_WAIT, 0, 0, 0);
        applyStimulus("tmo_w2",    0, I_NONE, E_WAIT, 0, 0, 0);
        applyStimulus("tmo_w3",    0, I_NONE, E_WAIT, 0, 0, 0);
        applyStimulus("tmo_pulse", 0, I_NONE, E_PASS, 1, 1, 1);
        applyStimulus("tmo_clear", 0, I_NONE, E_WAIT, 1, 1, 0);
        applyStimulus("tmo_v1",    0, I_NONE, E_WAIT, 1, 1, 0);
        applyStimulus("tmo_v2",    0, I_NONE, E_WAIT, 1, 1, 0);
        applyStimulus("tmo_v3",    0, I_NONE, E_WAIT, 1, 1, 0);
        applyStimulus("tmo_over",  0, I_NONE, E_OVER, 1, 2, 0);
        applyStimulus("tmo_regp",  0, I_GO,   E_INIT, 1, 2, 0);
        applyStimulus("tmo_reini", 0, I_IE,   E_WAIT, 0, 0, 0);
`else
        for (int i = 0; i < 100; i++) begin
            applyStimulus("wait_no_tmo", 0, I_NONE, E_WAIT, 0, 0, 0);
        end
`endif

        applyStimulus("h_ack1", 0, I_ACK, E_HOLD, 0, 0, 0);
        applyStimulus("h_ack2", 0, I_ACK, E_HOLD, 0, 0, 0);

        // Asynchronous reset while holding: outputs must clear before the next clock edge
        @(negedge clock);
        expectOutput("rst_async_a", 0, E_WELC, 0, 0, 0, cyc);
        expectOutput("rst_async_b", 1, E_WELC, 2, 0, 0, cyc);
        reset = 1'b1;
        applyStimulus("rst_held", 0, I_ACK, E_WELC, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        setInputs(0, I_ACK);
        expectOutput("rst_release", 0, E_WELC, 0, 0, 0, cyc + 1);

        applyStimulus("g_go",     0, I_GO,  E_INIT, 0, 0, 0);
        applyStimulus("g_init",   0, I_IE,  E_WAIT, 0, 0, 0);
        applyStimulus("g_ack",    0, I_ACK, E_HOLD, 0, 0, 0);
        applyStimulus("g_hold_ge", 0, I_ACK | I_GE, E_OVER, 0, 0, 0);
        applyStimulus("g_over",   0, I_NONE, E_OVER, 0, 0, 0);

        repeat (2) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_fail += exp_q.size();
            $display("[TB] FAIL scoreboard_drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
